// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC, imem request, 2-entry tagged queue, decode handshake
//
// Purpose:
//   Holds the fetch PC and issues one word read per cycle to instruction memory.
//   The returned word is tagged with the PC it came from and written into a
//   2-entry queue. The queue head goes to decode under a valid/stall handshake.
//   A redirect from execute squashes everything in flight and refetches.
//
// Ports:
//   i_clk              system clock, all state updates on posedge
//   i_reset            asynchronous active-high reset
//   o_imem_address     word-aligned read address (the fetch PC register)
//   i_imem_read_data   instruction word, valid the cycle after an accepted request
//   i_imem_busywait    memory refuses a request this cycle
//   i_redirect         branch/jump taken: flush and refetch
//   i_redirect_pc      redirect target, low two bits ignored
//   i_dec_stall        decode cannot accept an instruction this cycle
//   o_instr_valid      o_instruction/o_instr_pc hold a valid pair
//   o_instruction      head instruction word
//   o_instr_pc         address the head word was fetched from

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_imem_address,
    input  logic [31:0] i_imem_read_data,
    input  logic        i_imem_busywait,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_dec_stall,
    output logic        o_instr_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_instr_pc
);

    // Fetch PC and the single outstanding request
    logic [31:0] r_fetch_pc;
    logic [31:0] r_issue_pc;
    logic        r_pending;

    // 2-entry queue of {pc, word}
    logic [31:0] r_fifo_pc   [2];
    logic [31:0] r_fifo_word [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [2:0]  w_occupancy;
    logic [31:0] w_redirect_target;

    // Masking rather than slicing keeps every bit of the target port in use.
    assign w_redirect_target = i_redirect_pc & 32'hFFFF_FFFC;

    // A redirect squashes whatever decode sees this cycle, so no pop then.
    assign w_pop  = (r_count != 2'd0) && !i_dec_stall && !i_redirect;
    assign w_push = r_pending && !i_redirect;

    // Slots that will be occupied after this cycle if nothing new is issued:
    // entries held, plus the response about to land, minus the one leaving.
    // A pop implies count >= 1, so this never goes negative.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};

    // Issue only when the reply can be stored; this makes overflow impossible.
    assign w_issue = !i_redirect && !i_imem_busywait && (w_occupancy < 3'd2);

    // Fetch PC / outstanding request
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fetch_pc <= RESET_PC;
            r_issue_pc <= RESET_PC;
            r_pending  <= 1'b0;
        end else if (i_redirect) begin
            r_fetch_pc <= w_redirect_target;
            r_pending  <= 1'b0;
        end else if (w_issue) begin
            r_issue_pc <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_pending  <= 1'b1;
        end else begin
            r_pending  <= 1'b0;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_redirect) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_fifo_pc[0]   <= 32'd0;
            r_fifo_pc[1]   <= 32'd0;
            r_fifo_word[0] <= 32'd0;
            r_fifo_word[1] <= 32'd0;
        end else if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_issue_pc;
            r_fifo_word[r_wr_ptr] <= i_imem_read_data;
        end
    end

    // All outputs come straight from registers; no path from read data.
    assign o_imem_address = r_fetch_pc;
    assign o_instr_valid  = (r_count != 2'd0);
    assign o_instruction  = r_fifo_word[r_rd_ptr];
    assign o_instr_pc     = r_fifo_pc[r_rd_ptr];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] rdata;
    logic        busy;
    logic        redirect;
    logic [31:0] rpc;
    logic        stall;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;

    logic        w_rst;
    logic [31:0] w_rdata;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_ipc;

    int n_pass;
    int n_total;

    // Reference model: fetch PC, one optional in-flight PC, queue of delivered PCs
    logic [31:0] m_fpc;
    logic [31:0] m_ppc;
    bit          m_pend;
    logic [31:0] mq[$];

    logic [31:0] mem_addr_l;
    logic [31:0] w_addr_l;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .o_imem_address   (addr),
        .i_imem_read_data (rdata),
        .i_imem_busywait  (busy),
        .i_redirect       (redirect),
        .i_redirect_pc    (rpc),
        .i_dec_stall      (stall),
        .o_instr_valid    (valid),
        .o_instruction    (instr),
        .o_instr_pc       (ipc)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .i_clk            (clk),
        .i_reset          (w_rst),
        .o_imem_address   (w_addr),
        .i_imem_read_data (w_rdata),
        .i_imem_busywait  (1'b0),
        .i_redirect       (1'b0),
        .i_redirect_pc    (32'h0),
        .i_dec_stall      (1'b0),
        .o_instr_valid    (w_valid),
        .o_instruction    (w_instr),
        .o_instr_pc       (w_ipc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'h0090_0093;
            32'h4:   mem_word = 32'h0050_0113;
            32'h8:   mem_word = 32'h0020_8333;
            default: mem_word = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    task automatic model_reset();
        m_fpc  = 32'h0;
        m_ppc  = 32'h0;
        m_pend = 1'b0;
        mq.delete();
    endtask

    task automatic model_step();
        int  occ;
        bit  pop;
        bit  issue;
        if (rst) begin
            model_reset();
        end else if (redirect) begin
            mq.delete();
            m_pend = 1'b0;
            m_fpc  = rpc & 32'hFFFF_FFFC;
        end else begin
            pop   = (mq.size() != 0) && !stall;
            occ   = mq.size() + int'(m_pend) - int'(pop);
            issue = !busy && (occ < 2);
            if (pop) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_ppc);
            if (issue) begin
                m_ppc = m_fpc;
                m_fpc = m_fpc + 32'd4;
            end
            m_pend = issue;
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, advance the model,
    // then present the memory reply for the address seen this cycle.
    task automatic tick();
        logic exp_valid;
        @(negedge clk);
        exp_valid = (mq.size() != 0);
        n_total++;
        if (addr !== m_fpc) $display("FAIL model_addr t=%0t: got %h expected %h", $time, addr, m_fpc);
        else n_pass++;
        n_total++;
        if (valid !== exp_valid) $display("FAIL model_valid t=%0t: got %b expected %b", $time, valid, exp_valid);
        else n_pass++;
        if (exp_valid) begin
            n_total++;
            if (ipc !== mq[0]) $display("FAIL model_pc t=%0t: got %h expected %h", $time, ipc, mq[0]);
            else n_pass++;
            n_total++;
            if (instr !== mem_word(mq[0])) $display("FAIL model_instr t=%0t: got %h expected %h", $time, instr, mem_word(mq[0]));
            else n_pass++;
        end
        mem_addr_l = addr;
        w_addr_l   = w_addr;
        model_step();
        @(posedge clk);
        #1;
        rdata   = mem_word(mem_addr_l);
        w_rdata = mem_word(w_addr_l);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        busy     = 1'b0;
        stall    = 1'b0;
        rpc      = 32'h0;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_total++;
        if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else n_pass++;
        n_total++;
        if (instr !== 32'h0) $display("FAIL reset_instr: got %h expected 0", instr); else n_pass++;
        n_total++;
        if (ipc !== 32'h0) $display("FAIL reset_pc: got %h expected 0", ipc); else n_pass++;
        n_total++;
        if (addr !== 32'h0) $display("FAIL reset_addr: got %h expected 0", addr); else n_pass++;
        n_total++;
        if (w_addr !== 32'hFFFF_FFF8) $display("FAIL reset_addr_wrapdut: got %h expected fffffff8", w_addr); else n_pass++;
    endtask

    task automatic test_fetch_sequence();
        logic [31:0] ep;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (addr !== 32'(4 * i)) $display("FAIL seq_addr c%0d: got %h expected %h", i, addr, 32'(4 * i)); else n_pass++;
            n_total++;
            if (valid !== (i >= 2)) $display("FAIL seq_valid c%0d: got %b expected %b", i, valid, (i >= 2)); else n_pass++;
            if (i >= 2) begin
                ep = 32'(4 * (i - 2));
                n_total++;
                if (ipc !== ep || instr !== mem_word(ep))
                    $display("FAIL seq_pair c%0d: got %h/%h expected %h/%h", i, ipc, instr, ep, mem_word(ep));
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] ep;
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_total++;
            if (valid !== 1'b1 || ipc !== 32'h0 || instr !== 32'h0090_0093)
                $display("FAIL stall_head k%0d: got %b %h/%h expected 1 00000000/00900093", k, valid, ipc, instr);
            else n_pass++;
            n_total++;
            if (addr !== 32'h8) $display("FAIL stall_addr k%0d: got %h expected 00000008", k, addr); else n_pass++;
            tick();
        end
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ep = 32'(4 * k);
            n_total++;
            if (valid !== 1'b1 || ipc !== ep || instr !== mem_word(ep))
                $display("FAIL stall_release k%0d: got %b %h/%h expected 1 %h/%h", k, valid, ipc, instr, ep, mem_word(ep));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_busywait();
        do_reset();
        tick();
        busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (addr !== 32'h4) $display("FAIL busy_addr k%0d: got %h expected 00000004", k, addr); else n_pass++;
            tick();
        end
        busy = 1'b0;
        n_total++;
        if (addr !== 32'h4) $display("FAIL busy_release_addr: got %h expected 00000004", addr); else n_pass++;
        tick();
        n_total++;
        if (valid !== 1'b0) $display("FAIL busy_spurious: got %b expected 0", valid); else n_pass++;
        tick();
        n_total++;
        if (valid !== 1'b1 || ipc !== 32'h4 || instr !== 32'h0050_0113)
            $display("FAIL busy_word: got %b %h/%h expected 1 00000004/00500113", valid, ipc, instr);
        else n_pass++;
        tick();
    endtask

    task automatic test_redirect(input logic [31:0] target);
        do_reset();
        tick();
        tick();
        redirect = 1'b1;
        rpc      = target;
        tick();
        redirect = 1'b0;
        n_total++;
        if (addr !== 32'h20 || valid !== 1'b0)
            $display("FAIL redir_addr tgt=%h: got %h %b expected 00000020 0", target, addr, valid);
        else n_pass++;
        tick();
        n_total++;
        if (valid !== 1'b0) $display("FAIL redir_bubble tgt=%h: got %b expected 0", target, valid); else n_pass++;
        tick();
        n_total++;
        if (valid !== 1'b1 || ipc !== 32'h20 || instr !== mem_word(32'h20))
            $display("FAIL redir_word tgt=%h: got %b %h/%h expected 1 00000020/%h", target, valid, ipc, instr, mem_word(32'h20));
        else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        stall = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (valid !== 1'b0 || instr !== 32'h0 || ipc !== 32'h0)
            $display("FAIL areset_outputs: got %b %h/%h expected 0 00000000/00000000", valid, ipc, instr);
        else n_pass++;
        n_total++;
        if (addr !== 32'h0) $display("FAIL areset_addr: got %h expected 00000000", addr); else n_pass++;
        model_reset();
        tick();
        stall = 1'b0;
        rst   = 1'b0;
        tick();
        tick();
        n_total++;
        if (valid !== 1'b1 || ipc !== 32'h0 || instr !== 32'h0090_0093)
            $display("FAIL areset_restart: got %b %h/%h expected 1 00000000/00900093", valid, ipc, instr);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            busy     = ($urandom_range(0, 3) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 11) == 0);
            rpc      = 32'($urandom_range(0, 255));
            tick();
        end
        busy     = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] ea;
        logic [31:0] ep;
        w_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ea = 32'hFFFF_FFF8 + 32'(4 * i);
            n_total++;
            if (w_addr !== ea) $display("FAIL wrap_addr c%0d: got %h expected %h", i, w_addr, ea); else n_pass++;
            if (i >= 2) begin
                ep = 32'hFFFF_FFF8 + 32'(4 * (i - 2));
                n_total++;
                if (w_valid !== 1'b1 || w_ipc !== ep || w_instr !== mem_word(ep))
                    $display("FAIL wrap_pair c%0d: got %b %h/%h expected 1 %h/%h", i, w_valid, w_ipc, w_instr, ep, mem_word(ep));
                else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        w_rst    = 1'b1;
        rdata    = 32'h0;
        w_rdata  = 32'h0;
        busy     = 1'b0;
        redirect = 1'b0;
        rpc      = 32'h0;
        stall    = 1'b0;
        mem_addr_l = 32'h0;
        w_addr_l   = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_fetch_sequence();
        test_stall();
        test_busywait();
        test_redirect(32'h20);
        test_redirect(32'h23);
        test_async_reset();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that drives the instruction memory. Holds the fetch PC, issues one word read per cycle to instruction memory, honours its BUSYWAIT, and buffers returned words in a 2-entry queue with PC tags. It hands instruction/PC pairs to decode under a valid/stall handshake, and squashes stale fetches on a branch/jump redirect from execute.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- CLK  input  1  system clock; all state updates on posedge
- RESET  input  1  asynchronous, active-high reset
- IMEM_ADDRESS  output  32  read address to instruction memory; always word-aligned (bits [1:0] = 00)
- IMEM_READ_DATA  input  32  instruction word, valid in the cycle after an accepted request
- IMEM_BUSYWAIT  input  1  memory not accepting a request this cycle
- REDIRECT  input  1  branch/jump taken; flush and refetch
- REDIRECT_PC  input  32  redirect target; bits [1:0] ignored and forced to 00
- DEC_STALL  input  1  decode cannot accept an instruction this cycle
- INSTR_VALID  output  1  INSTRUCTION/INSTR_PC hold a valid pair
- INSTRUCTION  output  32  head instruction word
- INSTR_PC  output  32  address the head word was fetched from

## Operation
- State:
  - fetch_pc (32)
  - pending flag (request issued last cycle, response due this cycle)
  - 2-entry FIFO of {pc, word} with rd_ptr, wr_ptr (1 bit each) and count (0..2)
- IMEM_ADDRESS = fetch_pc, driven continuously from the register.
- issue = !REDIRECT && !IMEM_BUSYWAIT && (count + pending - pop) < 2.
  - On issue: pending <= 1, issue_pc register <= fetch_pc, fetch_pc <= fetch_pc + 4 (32-bit wrap: FFFF_FFFC -> 0000_0000).
  - Otherwise: pending <= 0, fetch_pc holds.
- Response: when pending && !REDIRECT, push {issue_pc, IMEM_READ_DATA}. The space check above guarantees the push never overflows.
- pop = INSTR_VALID && !DEC_STALL && !REDIRECT.
- INSTR_VALID = (count != 0). INSTRUCTION and INSTR_PC are the FIFO head, with no combinational path from IMEM_READ_DATA.
- Simultaneous push and pop: count unchanged, both pointers advance.
- REDIRECT in cycle N (has priority over everything):
  - FIFO count, pointers and pending cleared at end of N.
  - Any response arriving in N is discarded.
  - No request issued in N.
  - fetch_pc <= {REDIRECT_PC[31:2], 2'b00}.
  - INSTR_VALID is still shown in N, but decode must treat it as squashed; no pop occurs.
- BUSYWAIT while a response is pending does not affect that response; it only blocks new issue.
- Reset (async, any time, including mid-fetch):
  - fetch_pc = RESET_PC
  - pending = 0; count, rd_ptr, wr_ptr = 0
  - INSTR_VALID = 0, INSTRUCTION = 0, INSTR_PC = 0; storage cleared to 0
  - IMEM_ADDRESS = RESET_PC

## Timing
- Request accepted in cycle N (issue = 1), word on IMEM_READ_DATA in N+1, written at end of N+1, INSTR_VALID in N+2. Fetch-to-decode latency is 2 cycles.
- Steady state (no stall, no busywait): one instruction per cycle, consecutive PCs.
- First fetch after reset deassert: issue in the first cycle, first INSTR_VALID two cycles later with INSTR_PC = RESET_PC.
- Redirect in N: target issued in N+1, target instruction valid in N+3. That is 2 bubble cycles (N+1, N+2) after the redirect cycle.
- DEC_STALL held: at most 2 words buffered. Issue stops when count + pending reaches 2, so no word is ever lost or duplicated. On release, fetch resumes and throughput returns to 1/cycle.
- BUSYWAIT held k cycles: fetch_pc and IMEM_ADDRESS stay constant for k cycles, and issue happens in the first non-busy cycle.

## Test plan
- Reset, RESET_PC = 0, memory holds 0x00900093, 0x00500113, 0x00208333 at 0, 4, 8:
  - INSTR_VALID first rises 2 cycles after reset release.
  - Pairs (0, 00900093), (4, 00500113), (8, 00208333) appear on consecutive cycles.
- DEC_STALL = 1 for 5 cycles from the first valid cycle:
  - Head stays (0, 00900093); count saturates at 2; IMEM_ADDRESS holds at 8.
  - After release, 4 and then 8 follow with no gap and no duplicate.
- IMEM_BUSYWAIT = 1 for 3 cycles with IMEM_ADDRESS = 4:
  - IMEM_ADDRESS stays 4 for those 3 cycles.
  - Instruction at 4 becomes valid exactly 2 cycles after BUSYWAIT falls.
  - No spurious pushes.
- REDIRECT = 1, REDIRECT_PC = 0x20, issued while a response is pending and the FIFO holds 1 entry:
  - Pending word and FIFO entry are dropped.
  - IMEM_ADDRESS = 0x20 next cycle; (0x20, word@0x20) valid 3 cycles after the redirect.
- REDIRECT_PC = 0x23: fetch resumes at 0x20, confirming the low bits are forced to 00.
- Async RESET asserted mid-stream, between clock edges, with count = 2:
  - Outputs clear immediately, without waiting for CLK.
  - IMEM_ADDRESS = RESET_PC.
  - After release, the sequence restarts from RESET_PC.
- PC wrap: RESET_PC = 0xFFFF_FFF8 gives fetch PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
